// File: rtl/brisc_pkg.sv
// ============================================================================
// brisc_pkg : shared register-file sizing and register-index type
// Revision  : 1.0
// ============================================================================
`default_nettype none

package brisc_pkg;

  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/reg_sb8.sv
// ============================================================================
// reg_sb8 : per-register pending-write (busy) flags with reservation handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_sb8
  import brisc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_fire,
  input  reg_idx_t            i_wr_addr,
  input  logic                i_rsv_valid,
  input  reg_idx_t            i_rsv_addr,
  output logic                o_rsv_ready,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_same_reg_wr;
  logic                w_rsv_fire;

  // A write landing this cycle frees the register in time for a new owner.
  assign w_same_reg_wr = i_wr_fire && (i_wr_addr == i_rsv_addr);
  assign o_rsv_ready   = !r_busy[i_rsv_addr] || w_same_reg_wr;
  assign w_rsv_fire    = i_rsv_valid && o_rsv_ready;

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr_fire) begin
      w_busy_nxt[i_wr_addr] = 1'b0;
    end
    // Reservation applied last so it wins over a same-register clear.
    if (w_rsv_fire) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/reg_bank8.sv
// ============================================================================
// reg_bank8 : 8-entry register bank, r0 hardwired to zero, optional scoreboard
// Revision  : 1.0   (scoreboard enabled by macro BRISC_SCOREBOARD_EN)
// ============================================================================
`default_nettype none

module reg_bank8
  import brisc_pkg::*;
#(
  parameter int dw = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [dw-1:0]         wr_data,
  input  logic                  rsv_valid,
  output logic                  rsv_ready,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic [NUM_REGS-1:0]   busy,
  output logic [dw-1:0]         data_0,
  output logic [dw-1:0]         data_1,
  output logic [dw-1:0]         data_2,
  output logic [dw-1:0]         data_3,
  output logic [dw-1:0]         data_4,
  output logic [dw-1:0]         data_5,
  output logic [dw-1:0]         data_6,
  output logic [dw-1:0]         data_7
);

  logic          r_wr_ready;
  logic          w_wr_fire;
  logic [dw-1:0] r_regs [1:NUM_REGS-1];

  // Held low for the first cycle after reset release, then permanently high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ready <= 1'b0;
    end else begin
      r_wr_ready <= 1'b1;
    end
  end

  assign wr_ready  = r_wr_ready;
  assign w_wr_fire = wr_valid && r_wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wr_fire && (wr_addr == reg_idx_t'(i))) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  assign data_0 = '0;
  assign data_1 = r_regs[1];
  assign data_2 = r_regs[2];
  assign data_3 = r_regs[3];
  assign data_4 = r_regs[4];
  assign data_5 = r_regs[5];
  assign data_6 = r_regs[6];
  assign data_7 = r_regs[7];

`ifdef BRISC_SCOREBOARD_EN
  reg_sb8 u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_fire   (w_wr_fire),
    .i_wr_addr   (wr_addr),
    .i_rsv_valid (rsv_valid),
    .i_rsv_addr  (rsv_addr),
    .o_rsv_ready (rsv_ready),
    .o_busy      (busy)
  );
`else
  logic w_unused_rsv;

  assign busy         = '0;
  assign rsv_ready    = 1'b1;
  assign w_unused_rsv = ^{rsv_valid, rsv_addr};
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_bank8.sv
// ============================================================================
// tb_reg_bank8 : directed + randomized bench with behavioural register model
// Revision     : 1.0   (follows BRISC_SCOREBOARD_EN like the design)
// ============================================================================
`default_nettype none

module tb_reg_bank8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       rsv_valid = 1'b0;
  logic       rsv_ready;
  logic [2:0] rsv_addr = 3'd0;
  logic [7:0] busy;
  logic [7:0] data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7;
  logic [7:0] dut_data [8];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_bank8 #(.dw(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
    .busy(busy),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .data_4(data_4), .data_5(data_5), .data_6(data_6), .data_7(data_7)
  );

  assign dut_data[0] = data_0;
  assign dut_data[1] = data_1;
  assign dut_data[2] = data_2;
  assign dut_data[3] = data_3;
  assign dut_data[4] = data_4;
  assign dut_data[5] = data_5;
  assign dut_data[6] = data_6;
  assign dut_data[7] = data_7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [8] = '{default: 8'h00};
  bit         m_busy [8] = '{default: 1'b0};
  int         m_cycles_since_rst = 0;
  bit         m_hold = 1'b0;

  function automatic bit m_wr_ready();
    return rst_n && (m_cycles_since_rst >= 1);
  endfunction

  function automatic bit m_rsv_ready();
`ifdef BRISC_SCOREBOARD_EN
    return !m_busy[rsv_addr] || (wr_valid && m_wr_ready() && wr_addr == rsv_addr);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = 8'h00;
        m_busy[i] = 1'b0;
      end
      m_cycles_since_rst = 0;
      m_hold = 1'b0;
    end else begin
      bit acc_w, grant;
      acc_w = wr_valid && m_wr_ready();
      grant = rsv_valid && m_rsv_ready();
      if (acc_w && wr_addr != 0) m_regs[wr_addr] = wr_data;
`ifdef BRISC_SCOREBOARD_EN
      if (acc_w) m_busy[wr_addr] = 1'b0;
      if (grant && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
`endif
      m_hold = rsv_valid && !grant;
      m_cycles_since_rst++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) check($sformatf("data_%0d", i), dut_data[i], m_regs[i]);
    check("busy", busy, m_busy_vec());
    check("wr_ready", wr_ready, m_wr_ready());
    check("rsv_ready", rsv_ready, m_rsv_ready());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 8'h00);
    check("rst_data_7", data_7, 8'h00);

    // Reset release; first-cycle write must be refused.
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    #1 check("c1_wr_ready", wr_ready, 0);
    tick();
    check("c1_not_taken", data_3, 8'h00);
    check("c2_wr_ready", wr_ready, 1);
    tick();
    check("c3_data_3", data_3, 8'hA5);

    // Writes to r0 are discarded.
    wr_addr = 3'd0; wr_data = 8'hFF;
    tick();
    check("r0_data", data_0, 8'h00);
    check("r0_busy", busy[0], 0);
    wr_valid = 1'b0;

`ifdef BRISC_SCOREBOARD_EN
    rsv_valid = 1'b1; rsv_addr = 3'd5;
    #1 check("rsv5_ready", rsv_ready, 1);
    tick();
    rsv_valid = 1'b0;
    check("rsv5_busy", busy, 8'h20);
    #1 check("rsv5_again_ready", rsv_ready, 0);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 8'h11;
    tick();
    wr_valid = 1'b0;
    check("wr5_busy", busy, 8'h00);
    check("wr5_data", data_5, 8'h11);

    rsv_valid = 1'b1; rsv_addr = 3'd2;
    tick();
    check("rsv2_busy", busy, 8'h04);
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C;
    #1 check("same_cycle_rsv_ready", rsv_ready, 1);
    tick();
    rsv_valid = 1'b0;
    check("same_cycle_data_2", data_2, 8'h3C);
    check("same_cycle_busy_2", busy[2], 1);
    tick();
    wr_valid = 1'b0;
    check("release_busy_2", busy, 8'h00);
`else
    rsv_valid = 1'b1; rsv_addr = 3'd4;
    for (int k = 0; k < 3; k++) begin
      #1 check("nosb_rsv_ready", rsv_ready, 1);
      check("nosb_busy", busy, 8'h00);
      tick();
    end
    rsv_valid = 1'b0;
`endif

    // Fill r1..r7, reserve them all, then assert reset mid-cycle.
    for (int i = 1; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 8'(i * 8'h11);
      tick();
    end
    wr_valid = 1'b0;
    check("fill_data_6", data_6, 8'h66);
`ifdef BRISC_SCOREBOARD_EN
    for (int i = 1; i < 8; i++) begin
      rsv_valid = 1'b1; rsv_addr = 3'(i);
      tick();
    end
    rsv_valid = 1'b0;
    check("fill_busy", busy, 8'hFE);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 8'h00);
    check("async_wr_ready", wr_ready, 0);
    for (int i = 0; i < 8; i++) check($sformatf("async_data_%0d", i), dut_data[i], 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized phase with occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      wr_valid = ($urandom % 3) != 0;
      wr_addr  = 3'($urandom);
      wr_data  = 8'($urandom);
      if (!m_hold) begin
        rsv_valid = ($urandom % 2) != 0;
        rsv_addr  = 3'($urandom);
      end
      tick();
    end
    wr_valid = 1'b0;
    rsv_valid = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
